// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 memory responder slice.
package mips32_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // The WAIT counter starts at WAIT_CYC-1 so that RESP is entered after exactly WAIT_CYC cycles.
  function automatic logic [2:0] wait_init(input int wait_cyc);
    return (wait_cyc > 0) ? 3'(wait_cyc - 1) : 3'd0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word memory: synchronous write, combinational read on the same address.
module mem_array
  import mips32_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: the array deliberately has no reset; a reset must leave stored words intact.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder shared by an instruction-fetch port and a data port,
// with round-robin arbitration and a single outstanding transaction.
module mem_responder
  import mips32_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              busy
);

  localparam logic [2:0] CNT_INIT = wait_init(WAIT_CYC);

  state_t            state;
  logic [2:0]        cnt;
  logic              last_d;

  logic              own_d;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [WORD_W-1:0] own_wdata;

  logic              idle;
  logic              grant;
  logic              enter_resp;
  logic              acc_d;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [WORD_W-1:0] mem_rdata;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign idle  = rst_n && (state == IDLE);
  assign d_gnt = idle && d_req && (!i_req || !last_d);
  assign i_gnt = idle && i_req && (!d_req || last_d);
  assign grant = i_gnt || d_gnt;
  assign busy  = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d      = own_d;
    acc_we     = own_we;
    acc_addr   = own_addr;
    acc_wdata  = own_wdata;
    enter_resp = (state == WAIT) && (cnt == 3'd0);
    // With no wait states the access completes straight from IDLE, using the live request.
    if (WAIT_CYC == 0) begin
      acc_d      = d_gnt;
      acc_we     = d_gnt && d_we;
      acc_addr   = d_gnt ? d_addr : i_addr;
      acc_wdata  = d_wdata;
      enter_resp = grant;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (enter_resp && acc_we),
    .addr (acc_addr),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      last_d    <= 1'b0;
      own_d     <= 1'b0;
      own_we    <= 1'b0;
      own_addr  <= '0;
      own_wdata <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (enter_resp) begin
        if (acc_d) begin
          d_rvalid <= 1'b1;
          d_rdata  <= acc_we ? '0 : mem_rdata;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= mem_rdata;
        end
      end

      unique case (state)
        IDLE: begin
          if (grant) begin
            own_d     <= d_gnt;
            own_we    <= d_gnt && d_we;
            own_addr  <= d_gnt ? d_addr : i_addr;
            own_wdata <= d_wdata;
            last_d    <= d_gnt;
            cnt       <= CNT_INIT;
            state     <= (WAIT_CYC == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) state <= RESP;
          else             cnt   <= cnt - 3'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder: two instances (2 and 0 wait states)
// checked every cycle against a transaction-level model of grants, latency and memory.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [1:0]  i_req, d_req, d_we;
  logic [9:0]  i_addr [2];
  logic [9:0]  d_addr [2];
  logic [31:0] d_wdata [2];
  logic [1:0]  i_gnt, i_rvalid, d_gnt, d_rvalid, busy;
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]),
    .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .busy(busy[0])
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]),
    .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .busy(busy[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: per instance, the cycle at which a new grant becomes possible,
  // the single pending transaction and a word-level memory image.
  int          wc [2] = '{2, 0};
  int          cyc;
  int          free_cyc [2];
  bit          last_d [2];
  bit          pv [2];
  int          pc [2];
  bit          pd [2];
  bit          pwe [2];
  logic [9:0]  pa [2];
  logic [31:0] pw [2];
  logic [31:0] mm [2][1024];
  bit          mk [2][1024];
  logic [31:0] hi [2];
  logic [31:0] hd [2];
  bit          hik [2];
  bit          hdk [2];
  bit          gi [2];
  bit          gd [2];
  logic [9:0]  pool [8] = '{10'd0, 10'd1, 10'd5, 10'd10, 10'd1023, 10'd3, 10'd512, 10'd1022};

  function automatic string tg(input int x, input string name);
    return $sformatf("w%0d %s cyc%0d", wc[x], name, cyc);
  endfunction

  task automatic model_cycle(input int x);
    bit idle, ri, rd;
    idle = (cyc >= free_cyc[x]);
    ri = 1'b0;
    rd = 1'b0;
    gi[x] = 1'b0;
    gd[x] = 1'b0;
    if (idle) begin
      if (d_req[x] && (!i_req[x] || !last_d[x])) gd[x] = 1'b1;
      else if (i_req[x])                         gi[x] = 1'b1;
    end
    if (pv[x] && pc[x] == cyc) begin
      pv[x] = 1'b0;
      if (pd[x]) begin
        rd = 1'b1;
        if (pwe[x]) begin
          mm[x][pa[x]] = pw[x];
          mk[x][pa[x]] = 1'b1;
          hd[x]  = 32'h0;
          hdk[x] = 1'b1;
        end else begin
          hd[x]  = mm[x][pa[x]];
          hdk[x] = mk[x][pa[x]];
        end
      end else begin
        ri = 1'b1;
        hi[x]  = mm[x][pa[x]];
        hik[x] = mk[x][pa[x]];
      end
    end
    check(tg(x, "i_gnt"),    32'(i_gnt[x]),    32'(gi[x]));
    check(tg(x, "d_gnt"),    32'(d_gnt[x]),    32'(gd[x]));
    check(tg(x, "i_rvalid"), 32'(i_rvalid[x]), 32'(ri));
    check(tg(x, "d_rvalid"), 32'(d_rvalid[x]), 32'(rd));
    check(tg(x, "busy"),     32'(busy[x]),     32'(!idle));
    if (hik[x]) check(tg(x, "i_rdata"), i_rdata[x], hi[x]);
    if (hdk[x]) check(tg(x, "d_rdata"), d_rdata[x], hd[x]);
    if (gi[x] || gd[x]) begin
      pv[x]       = 1'b1;
      pc[x]       = cyc + wc[x] + 1;
      pd[x]       = gd[x];
      pwe[x]      = gd[x] && d_we[x];
      pa[x]       = gd[x] ? d_addr[x] : i_addr[x];
      pw[x]       = d_wdata[x];
      free_cyc[x] = cyc + wc[x] + 2;
      last_d[x]   = gd[x];
    end
  endtask

  // Entered and left at posedge+1: inputs are already driven for this cycle.
  task automatic step();
    @(negedge clk);
    for (int x = 0; x < 2; x++) model_cycle(x);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    for (int x = 0; x < 2; x++) begin
      i_req[x] = 1'b1;
      d_req[x] = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    for (int x = 0; x < 2; x++) begin
      check(tg(x, "rst i_gnt"),    32'(i_gnt[x]),    32'h0);
      check(tg(x, "rst d_gnt"),    32'(d_gnt[x]),    32'h0);
      check(tg(x, "rst i_rvalid"), 32'(i_rvalid[x]), 32'h0);
      check(tg(x, "rst d_rvalid"), 32'(d_rvalid[x]), 32'h0);
      check(tg(x, "rst busy"),     32'(busy[x]),     32'h0);
      check(tg(x, "rst i_rdata"),  i_rdata[x],       32'h0);
      check(tg(x, "rst d_rdata"),  d_rdata[x],       32'h0);
      free_cyc[x] = 0;
      last_d[x]   = 1'b0;
      pv[x]       = 1'b0;
      hi[x]       = 32'h0;
      hd[x]       = 32'h0;
      hik[x]      = 1'b1;
      hdk[x]      = 1'b1;
      gi[x]       = 1'b0;
      gd[x]       = 1'b0;
      i_req[x]    = 1'b0;
      d_req[x]    = 1'b0;
      d_we[x]     = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pv[0] || pv[1] || cyc < free_cyc[0] || cyc < free_cyc[1]) begin
      step();
      if (++n > 20) begin
        $display("FAIL wait_idle: still busy after %0d cycles", n);
        $fatal(1, "bench stopped");
      end
    end
  endtask

  task automatic xfer(input bit is_d, input bit we, input logic [9:0] a, input logic [31:0] wd);
    bit done [2] = '{1'b0, 1'b0};
    int n = 0;
    for (int x = 0; x < 2; x++) begin
      if (is_d) begin
        d_req[x] = 1'b1; d_we[x] = we; d_addr[x] = a; d_wdata[x] = wd;
      end else begin
        i_req[x] = 1'b1; i_addr[x] = a;
      end
    end
    while (!(done[0] && done[1])) begin
      step();
      for (int x = 0; x < 2; x++) begin
        if (gi[x] || gd[x]) begin
          done[x]  = 1'b1;
          i_req[x] = 1'b0;
          d_req[x] = 1'b0;
        end
      end
      if (++n > 20) begin
        $display("FAIL xfer: no grant after %0d cycles", n);
        $fatal(1, "bench stopped");
      end
    end
    wait_idle();
  endtask

  initial begin
    cyc = 0;
    for (int x = 0; x < 2; x++) begin
      i_addr[x] = '0; d_addr[x] = '0; d_wdata[x] = '0;
      for (int a = 0; a < 1024; a++) mk[x][a] = 1'b0;
    end
    i_req = '0; d_req = '0; d_we = '0;
    #2;
    apply_reset();

    // Store then load at word 10: grant cycle 0, response cycle WAIT_CYC+1.
    xfer(1'b1, 1'b1, 10'd10, 32'hDEAD_BEEF);
    xfer(1'b1, 1'b0, 10'd10, 32'h0);

    // Preload the address pool, ending with the top word, then fetch it.
    for (int k = 0; k < 8; k++)
      if (pool[k] != 10'd10) xfer(1'b1, 1'b1, pool[k], $urandom);
    xfer(1'b1, 1'b1, 10'd1023, 32'h8C22_0004);
    xfer(1'b0, 1'b0, 10'd1023, 32'h0);

    // Continuous contention from reset: D wins first, then strict alternation.
    apply_reset();
    for (int x = 0; x < 2; x++) begin
      i_req[x] = 1'b1; i_addr[x] = 10'd1;
      d_req[x] = 1'b1; d_we[x] = 1'b0; d_addr[x] = 10'd5;
    end
    repeat (16) step();
    i_req = '0; d_req = '0;
    wait_idle();

    // Store aborted by reset during WAIT must not reach memory.
    xfer(1'b1, 1'b1, 10'd5, 32'h1111_2222);
    for (int x = 0; x < 2; x++) begin
      d_req[x] = 1'b1; d_we[x] = 1'b1; d_addr[x] = 10'd5; d_wdata[x] = 32'hBAD0_0000;
    end
    step();
    d_req = '0;
    step();
    apply_reset();
    xfer(1'b1, 1'b0, 10'd5, 32'h0);

    // Fetch raised then dropped while D is granted; D address moved after grant.
    apply_reset();
    for (int x = 0; x < 2; x++) begin
      d_req[x] = 1'b1; d_we[x] = 1'b0; d_addr[x] = 10'd10;
      i_req[x] = 1'b1; i_addr[x] = 10'd3;
    end
    step();
    for (int x = 0; x < 2; x++) begin
      i_req[x] = 1'b0; d_req[x] = 1'b0; d_addr[x] = 10'd1023;
    end
    wait_idle();

    // Random traffic: requests held until granted, occasional legal drops.
    repeat (400) begin
      for (int x = 0; x < 2; x++) begin
        if (i_req[x] && !gi[x]) begin
          if ($urandom_range(0, 15) == 0) i_req[x] = 1'b0;
        end else begin
          i_req[x]  = 1'($urandom_range(0, 1));
          i_addr[x] = pool[$urandom_range(0, 7)];
        end
        if (d_req[x] && !gd[x]) begin
          if ($urandom_range(0, 15) == 0) d_req[x] = 1'b0;
        end else begin
          d_req[x]   = 1'($urandom_range(0, 1));
          d_we[x]    = 1'($urandom_range(0, 1));
          d_addr[x]  = pool[$urandom_range(0, 7)];
          d_wdata[x] = $urandom;
        end
      end
      step();
    end
    i_req = '0; d_req = '0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
